// File: rtl/mdu_sequencer_pkg.sv
// Shared definitions for the E-stage multiply/divide sequencer.
// Op encodings, FSM states, default latencies and divide helpers.
package mdu_sequencer_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10
    } mdu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } mdu_state_t;

    localparam int MDU_MUL_CYCLES = 5;
    localparam int MDU_DIV_CYCLES = 10;

    // Returns {remainder, quotient}; a zero divisor is forced to 1.
    function automatic logic [63:0] udiv(input logic [31:0] n,
                                         input logic [31:0] d);
        logic [31:0] dd;
        dd = (d == 32'd0) ? 32'd1 : d;
        return {n % dd, n / dd};
    endfunction

    // Truncating signed divide built on magnitudes, so that
    // 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
    function automatic logic [63:0] sdiv(input logic [31:0] n,
                                         input logic [31:0] d);
        logic [31:0] na;
        logic [31:0] nd;
        logic [63:0] qr;
        logic [31:0] q;
        logic [31:0] r;
        na = n[31] ? (32'd0 - n) : n;
        nd = d[31] ? (32'd0 - d) : d;
        qr = udiv(na, nd);
        q  = (n[31] ^ d[31]) ? (32'd0 - qr[31:0]) : qr[31:0];
        r  = n[31] ? (32'd0 - qr[63:32]) : qr[63:32];
        return {r, q};
    endfunction

endpackage

// File: rtl/mdu_sequencer.sv
// Multi-cycle mult/div sequencer owning HI/LO.
// Serves mt/mf and drives the D-stage stall request.
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int MUL_CYCLES = MDU_MUL_CYCLES,
    parameter int DIV_CYCLES = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  op,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_mdu,
    output logic        busy,
    output logic        stall,
    output logic [31:0] rd,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    mdu_state_t  state;
    logic [CW-1:0] cnt;
    logic [3:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;

    logic        is_mul;
    logic        is_div;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [63:0] hilo;

    assign is_mul = (op == OP_MULT) || (op == OP_MULTU) ||
                    (op == OP_MADD) || (op == OP_MADDU);
    assign is_div = (op == OP_DIV) || (op == OP_DIVU);

    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};
    assign hilo   = {hi, lo};

    assign stall = reset & d_mdu & (start | busy);
    assign rd    = (op == OP_MFHI) ? hi :
                   (op == OP_MFLO) ? lo : 32'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            op_q  <= 4'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start && is_mul) begin
                        state <= S_MUL;
                        cnt   <= CW'(MUL_CYCLES - 1);
                        busy  <= 1'b1;
                        op_q  <= op;
                        a_q   <= a;
                        b_q   <= b;
                    end else if (start && is_div) begin
                        state <= S_DIV;
                        cnt   <= CW'(DIV_CYCLES - 1);
                        busy  <= 1'b1;
                        op_q  <= op;
                        a_q   <= a;
                        b_q   <= b;
                    end else if (op == OP_MTHI) begin
                        hi <= a;
                    end else if (op == OP_MTLO) begin
                        lo <= a;
                    end
                end
                S_MUL, S_DIV: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        case (op_q)
                            OP_MULT:  {hi, lo} <= prod_s;
                            OP_MULTU: {hi, lo} <= prod_u;
                            OP_MADD:  {hi, lo} <= hilo + prod_s;
                            OP_MADDU: {hi, lo} <= hilo + prod_u;
                            OP_DIV:   if (b_q != 32'd0) {hi, lo} <= sdiv(a_q, b_q);
                            OP_DIVU:  if (b_q != 32'd0) {hi, lo} <= udiv(a_q, b_q);
                            default:  ;
                        endcase
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A new md op while one is in flight is dropped by the FSM.
    a_start_busy: assert property (
        @(posedge clk) disable iff (!reset) !(start && busy)
    );

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer.
// Each scenario task checks its own expected values inline.
module tb_mdu_sequencer;

    logic        clk;
    logic        reset;
    logic [3:0]  op;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        d_mdu;
    logic        busy;
    logic        stall;
    logic [31:0] rd;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mdu_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .op    (op),
        .start (start),
        .a     (a),
        .b     (b),
        .d_mdu (d_mdu),
        .busy  (busy),
        .stall (stall),
        .rd    (rd),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Issue one md op, count busy cycles, check HI/LO hold and final values.
    task automatic run_md(input string name, input logic [3:0] o,
                          input logic [31:0] va, input logic [31:0] vb,
                          input int ncyc, input logic [31:0] ehi,
                          input logic [31:0] elo);
        int n;
        logic [31:0] h0;
        logic [31:0] l0;
        h0 = hi;
        l0 = lo;
        op = o; start = 1'b1; a = va; b = vb;
        #1;
        chk({name, "_busy_start"}, {31'd0, busy}, 32'd0);
        cyc();
        op = 4'd0; start = 1'b0; a = 32'd0; b = 32'd0;
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            if (hi !== h0 || lo !== l0) begin
                errors++;
                $display("FAIL %s_hold: hi/lo 0x%08h/0x%08h want 0x%08h/0x%08h",
                         name, hi, lo, h0, l0);
            end
            checks++;
            n++;
            cyc();
        end
        chk({name, "_cycles"}, n, ncyc);
        chk({name, "_hi"}, hi, ehi);
        chk({name, "_lo"}, lo, elo);
    endtask

    task automatic mt(input logic [3:0] o, input logic [31:0] v);
        op = o; a = v;
        cyc();
        op = 4'd0; a = 32'd0;
    endtask

    task automatic test_reset();
        reset = 1'b0; op = 4'd0; start = 1'b1; a = 0; b = 0; d_mdu = 1'b1;
        #12;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        op = 4'd7;
        #1;
        chk("rst_rd", rd, 32'd0);
        start = 1'b0; d_mdu = 1'b0; op = 4'd0;
        #3 reset = 1'b1;
        cyc();
        mt(4'd5, 32'h1234_5678);
        mt(4'd6, 32'h9ABC_DEF0);
        chk("pre_hi", hi, 32'h1234_5678);
        op = 4'd1; start = 1'b1; a = 32'd3; b = 32'd4;
        cyc();
        op = 4'd0; start = 1'b0;
        cyc();
        cyc();
        #3 reset = 1'b0;
        #1;
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_hi", hi, 32'd0);
        chk("mid_lo", lo, 32'd0);
        #2 reset = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        chk("post_busy", {31'd0, busy}, 32'd0);
        chk("post_lo", lo, 32'd0);
    endtask

    task automatic test_mult();
        run_md("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_md("multu", 4'd2, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
    endtask

    task automatic test_div();
        run_md("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("divu0", 4'd4, 32'd7, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
        run_md("divu", 4'd4, 32'hFFFF_FFFF, 32'd16, 10, 32'd15, 32'h0FFF_FFFF);
        run_md("divpn", 4'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);
    endtask

    task automatic test_madd();
        mt(4'd5, 32'h0000_0001);
        mt(4'd6, 32'hFFFF_FFFF);
        chk("mthi", hi, 32'h1);
        chk("mtlo", lo, 32'hFFFF_FFFF);
        run_md("maddu", 4'd10, 32'd1, 32'd1, 5, 32'h2, 32'h0);
        run_md("madd", 4'd9, 32'hFFFF_FFFF, 32'd1, 5, 32'h1, 32'hFFFF_FFFF);
        mt(4'd5, 32'hFFFF_FFFF);
        run_md("maddu_wrap", 4'd10, 32'd1, 32'd1, 5, 32'h0, 32'h0);
    endtask

    task automatic test_stall();
        int n;
        d_mdu = 1'b1;
        op = 4'd1; start = 1'b1; a = 32'd2; b = 32'd3;
        #1;
        chk("stall_start", {31'd0, stall}, 32'd1);
        cyc();
        op = 4'd0; start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            chk("stall_busy", {31'd0, stall}, 32'd1);
            n++;
            cyc();
        end
        chk("stall_n", n, 5);
        chk("stall_after", {31'd0, stall}, 32'd0);
        chk("stall_lo", lo, 32'd6);
        d_mdu = 1'b0;
        op = 4'd3; start = 1'b1; a = 32'd9; b = 32'd4;
        #1;
        chk("nostall_start", {31'd0, stall}, 32'd0);
        cyc();
        op = 4'd0; start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            if (stall !== 1'b0) begin
                errors++;
                $display("FAIL nostall_busy: got %b want 0", stall);
            end
            checks++;
            n++;
            cyc();
        end
        chk("nostall_hi", hi, 32'd1);
        chk("nostall_lo", lo, 32'd2);
    endtask

    task automatic test_mf();
        op = 4'd7;
        #1;
        chk("mfhi", rd, 32'd1);
        op = 4'd8;
        #1;
        chk("mflo", rd, 32'd2);
        op = 4'd0;
        #1;
        chk("rd_none", rd, 32'd0);
        op = 4'd12;
        #1;
        chk("rd_op12", rd, 32'd0);
        op = 4'd2; start = 1'b1; a = 32'd5; b = 32'd5;
        cyc();
        start = 1'b0;
        op = 4'd5; a = 32'h55;
        cyc();
        op = 4'd7;
        #1;
        chk("mf_busy", rd, 32'd1);
        for (int i = 0; i < 3; i++) cyc();
        op = 4'd8;
        #1;
        chk("mf_commit", rd, 32'd2);
        cyc();
        #1;
        chk("mf_new", rd, 32'd25);
        op = 4'd7;
        #1;
        chk("mt_ignored", rd, 32'd0);
        op = 4'd0;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_madd();
        test_stall();
        test_mf();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
